// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// RV32M funct3 encodings, iteration FSM states and datapath constants.
package ex_mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // {rs1 is signed, rs2 is signed}; MUL treats both as signed since the low word is unaffected.
  function automatic logic [1:0] md_signed(input logic [2:0] op);
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: md_signed = 2'b11;
      MD_MULHSU:                       md_signed = 2'b10;
      default:                         md_signed = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative 32-step shift-add multiplier / restoring divider on operand magnitudes,
// with sign fixup and RV32M divide-by-zero handling applied in DONE.
module mdu_iter
  import ex_mdu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output mdu_state_e      o_state
);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic [2:0]       r_op;
  logic             r_sa;
  logic             r_sb;
  logic [XLEN-1:0]  r_ma;
  logic [XLEN-1:0]  r_mb;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_q;

  logic [1:0]       w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_is_div;

  logic [XLEN:0]    w_mul_sum;
  logic [XLEN:0]    w_div_sh;
  logic [XLEN+1:0]  w_div_diff;
  logic             w_div_ge;

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_rs1_orig;
  logic              w_div0;

  assign w_sgn    = md_signed(i_op);
  assign w_a_neg  = w_sgn[1] & i_a[XLEN-1];
  assign w_b_neg  = w_sgn[0] & i_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;
  assign w_is_div = r_op[2];

  // Multiply: add multiplicand into the high word, then shift {carry, hi, lo} right.
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_ma} : '0);

  // Divide: shift next dividend bit into the partial remainder and trial-subtract.
  // With no borrow the difference always fits in XLEN bits, so both top bits are zero.
  assign w_div_sh   = {r_acc, r_q[XLEN-1]};
  assign w_div_diff = {1'b0, w_div_sh} - {2'b00, r_mb};
  assign w_div_ge   = ~|w_div_diff[XLEN+1:XLEN];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_q     <= '0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op    <= i_op;
            r_sa    <= w_a_neg;
            r_sb    <= w_b_neg;
            r_ma    <= w_a_mag;
            r_mb    <= w_b_mag;
            r_acc   <= '0;
            r_q     <= i_op[2] ? w_a_mag : w_b_mag;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (!r_last) begin
            if (w_is_div) begin
              r_acc <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
              r_q   <= {r_q[XLEN-2:0], w_div_ge};
            end else begin
              r_acc <= w_mul_sum[XLEN:1];
              r_q   <= {w_mul_sum[0], r_q[XLEN-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) r_last <= 1'b1;
          end else begin
            // One settle cycle after the final iteration keeps the latency at 34 stalls.
            r_last  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_q + 1'b1) : r_q;
  assign w_rem_fix  = r_sa ? (~r_acc + 1'b1) : r_acc;
  assign w_rs1_orig = r_sa ? (~r_ma + 1'b1) : r_ma;
  assign w_div0     = (r_mb == '0);

  always_comb begin
    o_result = '0;
    case (r_op)
      MD_MUL:                       o_result = w_prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              o_result = w_div0 ? '1 : w_quo_fix;
      MD_REM, MD_REMU:              o_result = w_div0 ? w_rs1_orig : w_rem_fix;
      default:                      o_result = '0;
    endcase
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = (r_state == ST_DONE);
  assign o_state = r_state;

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage MDU wrapper: stall generation and the EX/MEM pipeline register.
// ALU results pass in one cycle; RV32M ops stall upstream until the iterator finishes.
module ex_mdu
  import ex_mdu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_vld,
  input  logic            i_flush,
  input  logic            i_is_md,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_rs1_rdata,
  input  logic [XLEN-1:0] i_rs2_rdata,
  input  logic [XLEN-1:0] i_res,
  input  logic [4:0]      i_rd_waddr,
  input  logic            i_rd_wen,
  input  logic            i_mem_reg,
  input  logic            i_dmem_ren,
  input  logic            i_dmem_wen,
  input  logic [2:0]      i_opsel,
  input  logic [XLEN-1:0] i_dmem_addr,
  input  logic [XLEN-1:0] i_dmem_wdata,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_nxt_pc,
  output logic            o_stall,
  output logic            o_vld,
  output logic [XLEN-1:0] o_res,
  output logic [XLEN-1:0] o_rs1_rdata,
  output logic [XLEN-1:0] o_rs2_rdata,
  output logic [4:0]      o_rd_waddr,
  output logic            o_rd_wen,
  output logic            o_mem_reg,
  output logic            o_dmem_ren,
  output logic            o_dmem_wen,
  output logic [2:0]      o_opsel,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_nxt_pc
);

  logic            w_md;
  logic            w_busy;
  logic            w_done;
  logic            w_cap;
  logic [XLEN-1:0] w_result;
  mdu_state_e      w_mdu_state;

  logic            r_vld;
  logic [XLEN-1:0] r_res;
  logic [XLEN-1:0] r_rs1_rdata;
  logic [XLEN-1:0] r_rs2_rdata;
  logic [4:0]      r_rd_waddr;
  logic            r_rd_wen;
  logic            r_mem_reg;
  logic            r_dmem_ren;
  logic            r_dmem_wen;
  logic [2:0]      r_opsel;
  logic [XLEN-1:0] r_dmem_addr;
  logic [XLEN-1:0] r_dmem_wdata;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_nxt_pc;

  // Handshake: while o_stall=1 upstream holds every EX input stable; an instruction
  // leaves EX on the first edge with o_stall=0, and o_vld marks a live EX/MEM entry.
  assign w_md    = i_vld & i_is_md & ~i_flush;
  assign o_stall = w_md & (w_mdu_state != ST_DONE);

  mdu_iter u_iter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_md),
    .i_flush  (i_flush),
    .i_op     (i_md_op),
    .i_a      (i_rs1_rdata),
    .i_b      (i_rs2_rdata),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_result (w_result),
    .o_state  (w_mdu_state)
  );

  // Payload fields are dead while the iterator runs, so they are only reloaded when it is not.
  assign w_cap = ~w_busy | w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld        <= 1'b0;
      r_res        <= '0;
      r_rs1_rdata  <= '0;
      r_rs2_rdata  <= '0;
      r_rd_waddr   <= '0;
      r_rd_wen     <= 1'b0;
      r_mem_reg    <= 1'b0;
      r_dmem_ren   <= 1'b0;
      r_dmem_wen   <= 1'b0;
      r_opsel      <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_inst       <= '0;
      r_pc         <= '0;
      r_nxt_pc     <= '0;
    end else begin
      r_vld <= i_vld & ~i_flush & (~i_is_md | w_done);
      if (w_cap) begin
        r_res        <= (w_md & w_done) ? w_result : i_res;
        r_rs1_rdata  <= i_rs1_rdata;
        r_rs2_rdata  <= i_rs2_rdata;
        r_rd_waddr   <= i_rd_waddr;
        r_rd_wen     <= i_rd_wen;
        r_mem_reg    <= i_mem_reg;
        r_dmem_ren   <= i_dmem_ren;
        r_dmem_wen   <= i_dmem_wen;
        r_opsel      <= i_opsel;
        r_dmem_addr  <= i_dmem_addr;
        r_dmem_wdata <= i_dmem_wdata;
        r_inst       <= i_inst;
        r_pc         <= i_pc;
        r_nxt_pc     <= i_nxt_pc;
      end
    end
  end

  assign o_vld        = r_vld;
  assign o_res        = r_res;
  assign o_rs1_rdata  = r_rs1_rdata;
  assign o_rs2_rdata  = r_rs2_rdata;
  assign o_rd_waddr   = r_rd_waddr;
  assign o_rd_wen     = r_rd_wen;
  assign o_mem_reg    = r_mem_reg;
  assign o_dmem_ren   = r_dmem_ren;
  assign o_dmem_wen   = r_dmem_wen;
  assign o_opsel      = r_opsel;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_inst       = r_inst;
  assign o_pc         = r_pc;
  assign o_nxt_pc     = r_nxt_pc;

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized self-checking bench for ex_mdu: arithmetic reference model, expected queue
// scoreboard with arrival-cycle checks, directed corners, flush and async reset.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int W = 101;  // {res, pc, rs1, rd_waddr}
  localparam int MD_STALLS = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vld, i_flush, i_is_md;
  logic [2:0]  i_md_op;
  logic [31:0] i_rs1_rdata, i_rs2_rdata, i_res;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen, i_mem_reg, i_dmem_ren, i_dmem_wen;
  logic [2:0]  i_opsel;
  logic [31:0] i_dmem_addr, i_dmem_wdata, i_inst, i_pc, i_nxt_pc;
  logic        o_stall, o_vld;
  logic [31:0] o_res, o_rs1_rdata, o_rs2_rdata;
  logic [4:0]  o_rd_waddr;
  logic        o_rd_wen, o_mem_reg, o_dmem_ren, o_dmem_wen;
  logic [2:0]  o_opsel;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_inst, o_pc, o_nxt_pc;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  ex_mdu dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(i_vld), .i_flush(i_flush), .i_is_md(i_is_md),
    .i_md_op(i_md_op), .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_res(i_res),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_mem_reg(i_mem_reg),
    .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen), .i_opsel(i_opsel),
    .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata), .i_inst(i_inst), .i_pc(i_pc),
    .i_nxt_pc(i_nxt_pc), .o_stall(o_stall), .o_vld(o_vld), .o_res(o_res),
    .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata), .o_rd_waddr(o_rd_waddr),
    .o_rd_wen(o_rd_wen), .o_mem_reg(o_mem_reg), .o_dmem_ren(o_dmem_ren),
    .o_dmem_wen(o_dmem_wen), .o_opsel(o_opsel), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 0;
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      MD_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle();
    i_vld = 1'b0; i_flush = 1'b0; i_is_md = 1'b0; i_md_op = '0;
  endtask

  task automatic set_instr(input logic is_md, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic [31:0] pc);
    i_vld = 1'b1; i_flush = 1'b0; i_is_md = is_md; i_md_op = op;
    i_rs1_rdata = a; i_rs2_rdata = b; i_res = res; i_pc = pc;
    i_rd_waddr = 5'($urandom_range(0, 31)); i_rd_wen = 1'($urandom_range(0, 1));
    i_mem_reg = 1'($urandom_range(0, 1)); i_dmem_ren = 1'($urandom_range(0, 1));
    i_dmem_wen = 1'($urandom_range(0, 1)); i_opsel = 3'($urandom_range(0, 7));
    i_dmem_addr = $urandom; i_dmem_wdata = $urandom; i_inst = $urandom;
    i_nxt_pc = pc + 32'd4;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the instruction.
  task automatic send(input string name, input logic is_md, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
    int   stalls;
    logic ok;
    logic [31:0] pc;
    pc = $urandom;
    set_instr(is_md, op, a, b, is_md ? $urandom : exp_res, pc);
    stalls = 0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!o_stall) begin ok = 1'b1; break; end
      stalls++;
    end
    check({name, "_stalls"}, 128'(stalls), 128'(is_md ? MD_STALLS : 0));
    if (!ok) begin
      i_flush = 1'b1;
      @(posedge clk); #1;
      drive_idle();
    end else begin
      @(posedge clk); #1;
      exp_q.push_back({exp_res, pc, a, i_rd_waddr});
      exp_cyc_q.push_back(cyc);
      drive_idle();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && o_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious_vld", 128'(o_vld), 128'(0));
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("exmem_out", 128'({o_res, o_pc, o_rs1_rdata, o_rd_waddr}), 128'(e));
        check("exmem_cycle", 128'(cyc), 128'(ec));
      end
    end
  end

  // i_vld must stay high while the iterator is in CALC (unless the op is being flushed).
  always @(posedge clk) begin
    if (rst_n && dut.u_iter.o_state == ST_CALC)
      assert (i_vld || i_flush) else $error("i_vld dropped during CALC");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, r;
    logic        is_md;
    drive_idle();
    set_instr(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 128'(o_vld), 128'(0));
    check("rst_res", 128'(o_res), 128'(0));
    check("rst_stall", 128'(o_stall), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Model pins against hand-computed values.
    check("pin_mul",    128'(ref_md(MD_MUL,    32'hFFFF_FFFF, 32'd2)), 128'(32'hFFFF_FFFE));
    check("pin_mulh",   128'(ref_md(MD_MULH,   32'hFFFF_FFFF, 32'd2)), 128'(32'hFFFF_FFFF));
    check("pin_mulhu",  128'(ref_md(MD_MULHU,  32'hFFFF_FFFF, 32'd2)), 128'(32'h0000_0001));
    check("pin_mulhsu", 128'(ref_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2)), 128'(32'hFFFF_FFFF));
    check("pin_div",    128'(ref_md(MD_DIV,    32'hFFFF_FFF9, 32'd2)), 128'(32'hFFFF_FFFD));
    check("pin_rem",    128'(ref_md(MD_REM,    32'hFFFF_FFF9, 32'd2)), 128'(32'hFFFF_FFFF));
    check("pin_divov",  128'(ref_md(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF)), 128'(32'h8000_0000));
    check("pin_rem0",   128'(ref_md(MD_REMU,   32'd9, 32'd0)), 128'(32'd9));

    // Directed vectors with literal expectations.
    send("alu",    1'b0, 3'd0,      32'd5,          32'd6,          32'h0000_1234);
    send("mul",    1'b1, MD_MUL,    32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE);
    send("mulh",   1'b1, MD_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF);
    send("mulhu",  1'b1, MD_MULHU,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001);
    send("mulhsu", 1'b1, MD_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF);
    send("div",    1'b1, MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    send("rem",    1'b1, MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    send("divu",   1'b1, MD_DIVU,   32'd7,          32'd2,          32'd3);
    send("remu",   1'b1, MD_REMU,   32'd7,          32'd2,          32'd1);
    send("div0",   1'b1, MD_DIV,    32'h1234_5678,  32'd0,          32'hFFFF_FFFF);
    send("rem0",   1'b1, MD_REM,    32'h8765_4321,  32'd0,          32'h8765_4321);
    send("divov",  1'b1, MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    send("remov",  1'b1, MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    send("alu2",   1'b0, 3'd0,      32'd0,          32'd0,          32'hCAFE_F00D);

    // Flush about ten iterations into CALC.
    set_instr(1'b1, MD_MUL, 32'd1234, 32'd5678, 32'd0, 32'h0000_2000);
    repeat (11) @(negedge clk);
    #1 i_flush = 1'b1;
    #1 check("flush_stall", 128'(o_stall), 128'(0));
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("flush_novld", 128'(o_vld), 128'(0));
    @(posedge clk); #1;
    send("mul_after_flush", 1'b1, MD_MUL, 32'd3, 32'd5, 32'd15);

    // Asynchronous reset in the middle of CALC.
    repeat (2) @(posedge clk); #1;
    set_instr(1'b1, MD_DIVU, 32'd1000, 32'd3, 32'd0, 32'h0000_4000);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    drive_idle();
    #1;
    check("arst_vld", 128'(o_vld), 128'(0));
    check("arst_pc", 128'(o_pc), 128'(0));
    check("arst_res", 128'(o_res), 128'(0));
    check("arst_stall", 128'(o_stall), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("divu_after_rst", 1'b1, MD_DIVU, 32'd100, 32'd7, 32'd14);

    // Randomized mix checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      is_md = ($urandom_range(0, 3) != 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick_operand();
      b     = pick_operand();
      r     = $urandom;
      send("rand", is_md, op, a, b, is_md ? ref_md(op, a, b) : r);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
